// File: rtl/st_dispatch_pkg.sv
// Shared constants and types for the two-way stream dispatcher.
package st_dispatch_pkg;

  localparam int unsigned MODE_FIELD = 0;
  localparam int unsigned MODE_RR    = 1;

  localparam int unsigned OCC_W = 2;

  // Skid buffer occupancy, 0..2 entries.
  typedef logic [OCC_W-1:0] occ_t;

endpackage

// File: rtl/st_skid_buf_2.sv
// Two-entry registered FIFO; head and status come straight from flops.
module st_skid_buf_2
  import st_dispatch_pkg::*;
#(
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head_data,
  output logic              head_valid,
  output logic              full
);

  occ_t              count;
  logic [DWIDTH-1:0] data_0;
  logic [DWIDTH-1:0] data_1;

  // Occupancy and storage update; a push into a full buffer is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= occ_t'(0);
      data_0 <= '0;
      data_1 <= '0;
    end else begin
      case (count)
        occ_t'(0): begin
          if (push) begin
            data_0 <= push_data;
            count  <= occ_t'(1);
          end
        end
        occ_t'(1): begin
          if (push && pop) begin
            data_0 <= push_data;
          end else if (push) begin
            data_1 <= push_data;
            count  <= occ_t'(2);
          end else if (pop) begin
            count <= occ_t'(0);
          end
        end
        occ_t'(2): begin
          if (pop) begin
            data_0 <= data_1;
            count  <= occ_t'(1);
          end
        end
        default: count <= occ_t'(0);
      endcase
    end
  end

  assign head_data  = data_0;
  assign head_valid = (count != occ_t'(0));
  assign full       = (count == occ_t'(2));

endmodule

// File: rtl/st_dispatch_2.sv
// Dispatches an input stream to two skid-buffered outputs by field or round-robin.
module st_dispatch_2
  import st_dispatch_pkg::*;
#(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned MODE    = 0,
  parameter int unsigned SEL_BIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DWIDTH-1:0] out_data_0,
  output logic              out_valid_0,
  input  logic              out_ready_0,
  output logic [DWIDTH-1:0] out_data_1,
  output logic              out_valid_1,
  input  logic              out_ready_1,
  output logic [31:0]       fwd_cnt_0,
  output logic [31:0]       fwd_cnt_1
);

  if (SEL_BIT >= DWIDTH || MODE > MODE_RR) begin : g_bad_param
    $error("st_dispatch_2: SEL_BIT must be < DWIDTH and MODE must be 0 or 1");
  end

  logic full_0;
  logic full_1;
  logic dest;
  logic accept;
  logic push_0;
  logic push_1;
  logic pop_0;
  logic pop_1;
  logic rr_ptr;

  // Destination and acceptance; field mode needs room on both sides to keep global order.
  always_comb begin
    dest     = 1'b0;
    in_ready = 1'b0;
    if (MODE == MODE_RR) begin
      if (rr_ptr) dest = full_1 ? 1'b0 : 1'b1;
      else        dest = full_0 ? 1'b1 : 1'b0;
      in_ready = !rst && (!full_0 || !full_1);
    end else begin
      dest     = in_data[SEL_BIT];
      in_ready = !rst && !full_0 && !full_1;
    end
  end

  assign accept = in_valid && in_ready;
  assign push_0 = accept && !dest;
  assign push_1 = accept && dest;
  assign pop_0  = out_valid_0 && out_ready_0;
  assign pop_1  = out_valid_1 && out_ready_1;

  // Round-robin pointer follows the last actual destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (accept && MODE == MODE_RR) begin
      rr_ptr <= !dest;
    end
  end

  // Wrap-around forwarded-beat statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt_0 <= 32'd0;
      fwd_cnt_1 <= 32'd0;
    end else begin
      if (pop_0) fwd_cnt_0 <= fwd_cnt_0 + 32'd1;
      if (pop_1) fwd_cnt_1 <= fwd_cnt_1 + 32'd1;
    end
  end

  st_skid_buf_2 #(.DWIDTH(DWIDTH)) u_buf_0 (
    .clk        (clk),
    .rst        (rst),
    .push       (push_0),
    .push_data  (in_data),
    .pop        (pop_0),
    .head_data  (out_data_0),
    .head_valid (out_valid_0),
    .full       (full_0)
  );

  st_skid_buf_2 #(.DWIDTH(DWIDTH)) u_buf_1 (
    .clk        (clk),
    .rst        (rst),
    .push       (push_1),
    .push_data  (in_data),
    .pop        (pop_1),
    .head_data  (out_data_1),
    .head_valid (out_valid_1),
    .full       (full_1)
  );

endmodule

// File: tb/tb_st_dispatch_2.sv
// Directed vector bench: one field-select and one round-robin dispatcher share stimulus.
module tb_st_dispatch_2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready_0;
  logic       out_ready_1;

  logic        a_in_ready, a_v0, a_v1;
  logic [7:0]  a_d0, a_d1;
  logic [31:0] a_c0, a_c1;
  logic        b_in_ready, b_v0, b_v1;
  logic [7:0]  b_d0, b_d1;
  logic [31:0] b_c0, b_c1;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  st_dispatch_2 #(.DWIDTH(8), .MODE(0), .SEL_BIT(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
    .out_data_0(a_d0), .out_valid_0(a_v0), .out_ready_0(out_ready_0),
    .out_data_1(a_d1), .out_valid_1(a_v1), .out_ready_1(out_ready_1),
    .fwd_cnt_0(a_c0), .fwd_cnt_1(a_c1)
  );

  st_dispatch_2 #(.DWIDTH(8), .MODE(1), .SEL_BIT(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
    .out_data_0(b_d0), .out_valid_0(b_v0), .out_ready_0(out_ready_0),
    .out_data_1(b_d1), .out_valid_1(b_v1), .out_ready_1(out_ready_1),
    .fwd_cnt_0(b_c0), .fwd_cnt_1(b_c1)
  );

  typedef struct {
    logic        rst;
    logic [7:0]  data;
    logic        valid;
    logic        r0;
    logic        r1;
    logic        ir;
    logic        v0;
    logic [7:0]  d0;
    logic        v1;
    logic [7:0]  d1;
    logic [31:0] c0;
    logic [31:0] c1;
  } vec_t;

  function automatic vec_t mk(logic r, logic [7:0] d, logic v, logic r0, logic r1,
                              logic ir, logic v0, logic [7:0] d0, logic v1, logic [7:0] d1,
                              logic [31:0] c0, logic [31:0] c1);
    vec_t t;
    t.rst = r; t.data = d; t.valid = v; t.r0 = r0; t.r1 = r1;
    t.ir = ir; t.v0 = v0; t.d0 = d0; t.v1 = v1; t.d1 = d1; t.c0 = c0; t.c1 = c1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Drive one vector at the falling edge, then compare the pre-edge state.
  task automatic run_vec(input vec_t t, input bit use_b, input string tag);
    logic        ir, v0, v1;
    logic [7:0]  d0, d1;
    logic [31:0] c0, c1;
    @(negedge clk);
    rst = t.rst; in_data = t.data; in_valid = t.valid;
    out_ready_0 = t.r0; out_ready_1 = t.r1;
    #1;
    if (use_b) begin
      ir = b_in_ready; v0 = b_v0; d0 = b_d0; v1 = b_v1; d1 = b_d1; c0 = b_c0; c1 = b_c1;
    end else begin
      ir = a_in_ready; v0 = a_v0; d0 = a_d0; v1 = a_v1; d1 = a_d1; c0 = a_c0; c1 = a_c1;
    end
    chk({tag, " in_ready"}, 32'(ir), 32'(t.ir));
    chk({tag, " out_valid_0"}, 32'(v0), 32'(t.v0));
    chk({tag, " out_valid_1"}, 32'(v1), 32'(t.v1));
    if (t.v0) chk({tag, " out_data_0"}, 32'(d0), 32'(t.d0));
    if (t.v1) chk({tag, " out_data_1"}, 32'(d1), 32'(t.d1));
    chk({tag, " fwd_cnt_0"}, c0, t.c0);
    chk({tag, " fwd_cnt_1"}, c1, t.c1);
  endtask

  task automatic reset_edge();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready_0 = 1'b1; out_ready_1 = 1'b1;
    @(posedge clk);
  endtask

  vec_t ta[24];
  vec_t tb[14];

  initial begin
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; out_ready_0 = 1'b0; out_ready_1 = 1'b0;

    // Field-select: reset with valid high, steering, back-pressure, push/pop together.
    //           rst  data   val r0 r1  ir v0 d0     v1 d1     c0  c1
    ta[0]  = mk(1, 8'h10, 1, 1, 1,  0, 0, 8'h00, 0, 8'h00, 0, 0);
    ta[1]  = mk(1, 8'h10, 1, 1, 1,  0, 0, 8'h00, 0, 8'h00, 0, 0);
    ta[2]  = mk(1, 8'h10, 1, 1, 1,  0, 0, 8'h00, 0, 8'h00, 0, 0);
    ta[3]  = mk(0, 8'h10, 1, 1, 1,  1, 0, 8'h00, 0, 8'h00, 0, 0);
    ta[4]  = mk(0, 8'h11, 1, 1, 1,  1, 1, 8'h10, 0, 8'h00, 0, 0);
    ta[5]  = mk(0, 8'h12, 1, 1, 1,  1, 0, 8'h00, 1, 8'h11, 1, 0);
    ta[6]  = mk(0, 8'h13, 1, 1, 1,  1, 1, 8'h12, 0, 8'h00, 1, 1);
    ta[7]  = mk(0, 8'h00, 0, 1, 1,  1, 0, 8'h00, 1, 8'h13, 2, 1);
    ta[8]  = mk(0, 8'h00, 0, 1, 1,  1, 0, 8'h00, 0, 8'h00, 2, 2);
    ta[9]  = mk(0, 8'h01, 1, 1, 0,  1, 0, 8'h00, 0, 8'h00, 2, 2);
    ta[10] = mk(0, 8'h03, 1, 1, 0,  1, 0, 8'h00, 1, 8'h01, 2, 2);
    ta[11] = mk(0, 8'h05, 1, 1, 0,  0, 0, 8'h00, 1, 8'h01, 2, 2);
    ta[12] = mk(0, 8'h05, 1, 1, 0,  0, 0, 8'h00, 1, 8'h01, 2, 2);
    ta[13] = mk(0, 8'h05, 1, 1, 1,  0, 0, 8'h00, 1, 8'h01, 2, 2);
    ta[14] = mk(0, 8'h05, 1, 1, 1,  1, 0, 8'h00, 1, 8'h03, 2, 3);
    ta[15] = mk(0, 8'h00, 0, 1, 1,  1, 0, 8'h00, 1, 8'h05, 2, 4);
    ta[16] = mk(0, 8'h00, 0, 1, 1,  1, 0, 8'h00, 0, 8'h00, 2, 5);
    ta[17] = mk(0, 8'h20, 1, 0, 1,  1, 0, 8'h00, 0, 8'h00, 2, 5);
    ta[18] = mk(0, 8'h22, 1, 1, 1,  1, 1, 8'h20, 0, 8'h00, 2, 5);
    ta[19] = mk(0, 8'h24, 1, 0, 1,  1, 1, 8'h22, 0, 8'h00, 3, 5);
    ta[20] = mk(0, 8'h26, 1, 1, 1,  0, 1, 8'h22, 0, 8'h00, 3, 5);
    ta[21] = mk(0, 8'h26, 1, 1, 1,  1, 1, 8'h24, 0, 8'h00, 4, 5);
    ta[22] = mk(0, 8'h00, 0, 1, 1,  1, 1, 8'h26, 0, 8'h00, 5, 5);
    ta[23] = mk(0, 8'h00, 0, 1, 1,  1, 0, 8'h00, 0, 8'h00, 6, 5);

    // Round-robin: alternate, skip full output 0, stall when both full.
    tb[0]  = mk(1, 8'h00, 0, 0, 1,  0, 0, 8'h00, 0, 8'h00, 0, 0);
    tb[1]  = mk(0, 8'h30, 1, 0, 1,  1, 0, 8'h00, 0, 8'h00, 0, 0);
    tb[2]  = mk(0, 8'h31, 1, 0, 1,  1, 1, 8'h30, 0, 8'h00, 0, 0);
    tb[3]  = mk(0, 8'h32, 1, 0, 1,  1, 1, 8'h30, 1, 8'h31, 0, 0);
    tb[4]  = mk(0, 8'h33, 1, 0, 1,  1, 1, 8'h30, 0, 8'h00, 0, 1);
    tb[5]  = mk(0, 8'h34, 1, 0, 1,  1, 1, 8'h30, 1, 8'h33, 0, 1);
    tb[6]  = mk(0, 8'h35, 1, 0, 1,  1, 1, 8'h30, 1, 8'h34, 0, 2);
    tb[7]  = mk(0, 8'h36, 1, 0, 0,  1, 1, 8'h30, 1, 8'h35, 0, 3);
    tb[8]  = mk(0, 8'h37, 1, 0, 0,  0, 1, 8'h30, 1, 8'h35, 0, 3);
    tb[9]  = mk(0, 8'h37, 1, 1, 0,  0, 1, 8'h30, 1, 8'h35, 0, 3);
    tb[10] = mk(0, 8'h37, 1, 0, 0,  1, 1, 8'h32, 1, 8'h35, 1, 3);
    tb[11] = mk(0, 8'h00, 0, 1, 1,  0, 1, 8'h32, 1, 8'h35, 1, 3);
    tb[12] = mk(0, 8'h00, 0, 1, 1,  1, 1, 8'h37, 1, 8'h36, 2, 4);
    tb[13] = mk(0, 8'h00, 0, 1, 1,  1, 0, 8'h00, 0, 8'h00, 3, 5);

    @(posedge clk);
    @(posedge clk);

    for (int i = 0; i < 24; i++) run_vec(ta[i], 1'b0, $sformatf("field[%0d]", i));

    reset_edge();
    for (int i = 0; i < 14; i++) run_vec(tb[i], 1'b1, $sformatf("rr[%0d]", i));

    // Counter wrap on output 0 of the field-select instance.
    reset_edge();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_data = 8'h40; out_ready_0 = 1'b0; out_ready_1 = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    force dut_a.fwd_cnt_0 = 32'hFFFF_FFFF;
    #1;
    release dut_a.fwd_cnt_0;
    #1;
    chk("wrap preload", a_c0, 32'hFFFF_FFFF);
    chk("wrap head valid", 32'(a_v0), 32'd1);
    out_ready_0 = 1'b1;
    @(negedge clk);
    #1;
    chk("wrap fwd_cnt_0", a_c0, 32'd0);
    chk("wrap buffer drained", 32'(a_v0), 32'd0);

    // Fill both buffers, then reset mid-operation; no stale beat may surface.
    out_ready_0 = 1'b0; out_ready_1 = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h50 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("fill in_ready", 32'(a_in_ready), 32'd0);
    chk("fill head_0", 32'(a_d0), 32'h50);
    chk("fill head_1", 32'(a_d1), 32'h51);
    rst = 1'b1; out_ready_0 = 1'b1; out_ready_1 = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("rst in_ready", 32'(a_in_ready), 32'd0);
    chk("rst out_valid_0", 32'(a_v0), 32'd0);
    chk("rst out_valid_1", 32'(a_v1), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-rst[%0d] out_valid_0", i), 32'(a_v0), 32'd0);
      chk($sformatf("post-rst[%0d] out_valid_1", i), 32'(a_v1), 32'd0);
      chk($sformatf("post-rst[%0d] fwd_cnt_1", i), a_c1, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
